// File: rtl/memory_pkg.sv
// Shared types and address-check helpers for the XLEN-parametrised simulation memory.
// Latency: none; the package holds only types and combinational functions.
// Backpressure: not applicable.
package memory_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        STORE = 2'd1,
        LR    = 2'd2,
        SC    = 2'd3
    } mem_op_t;

    // Response beat, sized for the widest XLEN so both widths share one type.
    typedef struct packed {
        logic [63:0] data;
        logic        exc;
    } mem_rsp_t;

    // A word access must sit on a natural XLEN/8-byte boundary.
    function automatic logic is_aligned(input logic [63:0] addr, input int xlen);
        if (xlen == 64) begin
            return addr[2:0] == 3'b000;
        end
        return addr[1:0] == 2'b00;
    endfunction

    // True when addr lies in [base, base + 2^abits).
    function automatic logic in_range(input logic [63:0] addr, input logic [63:0] base,
                                      input int abits);
        logic [63:0] off;
        off = addr - base;
        return (addr >= base) && ((off >> abits) == 64'd0);
    endfunction

endpackage

// File: rtl/mem_rsp_pipe.sv
// Valid/data delay line carrying one response channel of the memory.
// Latency: LATENCY cycles from accepted input to output valid when never stalled.
// Backpressure: bubbles collapse; input ready drops only when every stage is full and the output is held.
module mem_rsp_pipe #(
    parameter int WIDTH   = 33,
    parameter int LATENCY = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_vld_i,
    output logic             in_rdy_o,
    input  logic [WIDTH-1:0] in_dat_i,
    output logic             out_vld_o,
    input  logic             out_rdy_i,
    output logic [WIDTH-1:0] out_dat_o
);

    logic [LATENCY-1:0]            vld_q;
    logic [LATENCY-1:0][WIDTH-1:0] dat_q;
    logic [LATENCY-1:0]            stage_rdy;

    // A stage may load when it, or any stage downstream of it, is empty, or the output drains.
    always_comb begin : p_stage_rdy
        logic tail_full;
        stage_rdy = '0;
        tail_full = 1'b1;
        for (int i = LATENCY - 1; i >= 0; i--) begin
            tail_full    = tail_full & vld_q[i];
            stage_rdy[i] = out_rdy_i | ~tail_full;
        end
    end

    // Shift beats forward; empty stages carry zero data so idle outputs read as zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            if (stage_rdy[0]) begin
                vld_q[0] <= in_vld_i;
                dat_q[0] <= in_vld_i ? in_dat_i : '0;
            end
            for (int i = 1; i < LATENCY; i++) begin
                if (stage_rdy[i]) begin
                    vld_q[i] <= vld_q[i-1];
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign in_rdy_o  = stage_rdy[0];
    assign out_vld_o = vld_q[LATENCY-1];
    assign out_dat_o = dat_q[LATENCY-1];

endmodule

// File: rtl/memory_xlen.sv
// Byte-addressed simulation memory with a fetch channel and a data channel (load/store/LR/SC).
// Latency: LATENCY cycles from request accept to response valid; all reads and writes happen at accept.
// Backpressure: per-channel response pipe; request ready falls only when that pipe is full and stalled.
module memory_xlen
    import memory_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter int          ADDR_BITS = 20,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int          LATENCY   = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [XLEN-1:0]   if_req_addr,
    output logic              if_rsp_valid,
    input  logic              if_rsp_ready,
    output logic [XLEN-1:0]   if_rsp_data,
    output logic              if_rsp_exc,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  mem_op_t           d_req_op,
    input  logic [XLEN-1:0]   d_req_addr,
    input  logic [XLEN-1:0]   d_req_wdata,
    input  logic [XLEN/8-1:0] d_req_be,
    output logic              d_rsp_valid,
    input  logic              d_rsp_ready,
    output logic [XLEN-1:0]   d_rsp_data,
    output logic              d_rsp_exc
);

    localparam int NB   = XLEN / 8;
    localparam int OFFB = (XLEN == 64) ? 3 : 2;

    if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
        $error("memory_xlen: XLEN must be 32 or 64");
    end
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("memory_xlen: LATENCY must be 1..4");
    end
    if (ADDR_BITS <= OFFB) begin : g_bad_addr_bits
        $error("memory_xlen: ADDR_BITS too small for one word");
    end

    // Backing store; deliberately not reset so preloaded images survive.
    logic [7:0] mem [0:(1 << ADDR_BITS) - 1];

    logic            if_exc, d_exc, d_acc, sc_ok, d_wr;
    logic [XLEN-1:0] if_rdata, d_rdata, d_dat;
    logic [XLEN:0]   if_pipe_out, d_pipe_out;
    logic            rsv_valid_q, rsv_valid_d;
    logic [XLEN-1:0] rsv_addr_q, rsv_addr_d;

    assign if_exc = !is_aligned(64'(if_req_addr), XLEN)
                 || !in_range(64'(if_req_addr), BASE_ADDR, ADDR_BITS);
    assign d_exc  = !is_aligned(64'(d_req_addr), XLEN)
                 || !in_range(64'(d_req_addr), BASE_ADDR, ADDR_BITS);
    assign d_acc  = d_req_valid && d_req_ready;
    assign sc_ok  = rsv_valid_q && (rsv_addr_q == d_req_addr);
    assign d_wr   = d_acc && !d_exc && ((d_req_op == STORE) || (d_req_op == SC && sc_ok));

    // Little-endian word reads; the fetch sees the pre-store value of a same-cycle store.
    always_comb begin
        if_rdata = '0;
        d_rdata  = '0;
        for (int b = 0; b < NB; b++) begin
            if_rdata[8*b +: 8] = mem[{if_req_addr[ADDR_BITS-1:OFFB], OFFB'(b)}];
            d_rdata[8*b +: 8]  = mem[{d_req_addr[ADDR_BITS-1:OFFB], OFFB'(b)}];
        end
    end

    // Data-channel response payload: excepting requests and stores return zero, SC returns its fail flag.
    always_comb begin
        d_dat = '0;
        if (!d_exc) begin
            unique case (d_req_op)
                LOAD, LR: d_dat = d_rdata;
                SC:       d_dat = XLEN'(!sc_ok);
                default:  d_dat = '0;
            endcase
        end
    end

    // Byte-masked write for stores and successful SCs, performed at accept.
    always_ff @(posedge CLK) begin
        for (int b = 0; b < NB; b++) begin
            if (d_wr && d_req_be[b]) begin
                mem[{d_req_addr[ADDR_BITS-1:OFFB], OFFB'(b)}] <= d_req_wdata[8*b +: 8];
            end
        end
    end

    // Reservation next state: LR sets, SC always clears, a store to the reserved word clears.
    always_comb begin
        rsv_valid_d = rsv_valid_q;
        rsv_addr_d  = rsv_addr_q;
        if (d_acc && !d_exc) begin
            unique case (d_req_op)
                LR: begin
                    rsv_valid_d = 1'b1;
                    rsv_addr_d  = d_req_addr;
                end
                STORE: begin
                    if (rsv_valid_q && d_req_addr == rsv_addr_q) begin
                        rsv_valid_d = 1'b0;
                    end
                end
                SC:      rsv_valid_d = 1'b0;
                default: rsv_valid_d = rsv_valid_q;
            endcase
        end
    end

    // Reservation register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rsv_valid_q <= 1'b0;
            rsv_addr_q  <= '0;
        end else begin
            rsv_valid_q <= rsv_valid_d;
            rsv_addr_q  <= rsv_addr_d;
        end
    end

    mem_rsp_pipe #(.WIDTH(XLEN + 1), .LATENCY(LATENCY)) u_if_pipe (
        .clk_i     (CLK),
        .rst_ni    (RST_N),
        .in_vld_i  (if_req_valid),
        .in_rdy_o  (if_req_ready),
        .in_dat_i  ({if_exc, (if_exc ? {XLEN{1'b0}} : if_rdata)}),
        .out_vld_o (if_rsp_valid),
        .out_rdy_i (if_rsp_ready),
        .out_dat_o (if_pipe_out)
    );

    mem_rsp_pipe #(.WIDTH(XLEN + 1), .LATENCY(LATENCY)) u_d_pipe (
        .clk_i     (CLK),
        .rst_ni    (RST_N),
        .in_vld_i  (d_req_valid),
        .in_rdy_o  (d_req_ready),
        .in_dat_i  ({d_exc, d_dat}),
        .out_vld_o (d_rsp_valid),
        .out_rdy_i (d_rsp_ready),
        .out_dat_o (d_pipe_out)
    );

    assign {if_rsp_exc, if_rsp_data} = if_pipe_out;
    assign {d_rsp_exc, d_rsp_data}   = d_pipe_out;

endmodule

// File: doc/memory_xlen.md
# memory_xlen

Parametrised successor to the 32-bit simulation memory attached to the core. Serves an instruction-fetch channel and a data channel, each with a valid/ready request, a fixed-latency response and backpressure. Adds:
- XLEN of 32 or 64
- byte-masked stores
- alignment and range exceptions
- real LR/SC reservation tracking in place of an always-succeeding reservation

## Interface
Parameters:
- XLEN, 32, data word width; 32 or 64 only (elaboration error otherwise)
- ADDR_BITS, 20, log2 of backing-store bytes; byte offset = addr[ADDR_BITS-1:0]
- BASE_ADDR, 32'h8000_0000, first valid address; valid range is BASE_ADDR .. BASE_ADDR+2^ADDR_BITS-1
- LATENCY, 1, request-accept to response-valid cycles; 1..4

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  reset, asynchronous and active-low
- if_req_valid / if_req_ready  in/out  1  fetch request handshake
- if_req_addr  in  XLEN  fetch address
- if_rsp_valid / if_rsp_ready  out/in  1  fetch response handshake
- if_rsp_data  out  XLEN  fetched word
- if_rsp_exc  out  1  fetch exception
- d_req_valid / d_req_ready  in/out  1  data request handshake
- d_req_op  in  2  mem_op_t: LOAD=0, STORE=1, LR=2, SC=3
- d_req_addr  in  XLEN  data address
- d_req_wdata  in  XLEN  store data
- d_req_be  in  XLEN/8  store byte enables
- d_rsp_valid / d_rsp_ready  out/in  1  data response handshake
- d_rsp_data  out  XLEN  load/LR data; for SC, 0 = success, 1 = fail
- d_rsp_exc  out  1  data exception

## Operation
- A request is accepted when valid && ready. The response is the same beat LATENCY cycles later, unless stalled by backpressure.
- Exception conditions:
  - misaligned: addr[log2(XLEN/8)-1:0] != 0
  - out of range: addr outside the BASE_ADDR window
- An excepting request responds with exc=1 and data 0. It causes no write and no reservation change.
- LOAD: returns the word at addr, little-endian byte order.
- STORE: at acceptance, writes the bytes whose be bit is set; unmasked bytes are unchanged. Response data is 0. If the store's word address equals the reservation address, the reservation is cleared.
- LR: returns the word and sets the reservation: rsv_valid=1, rsv_addr=word address.
- SC: succeeds iff rsv_valid and rsv_addr matches.
  - Success: writes with be, response data 0.
  - Fail: no write, response data 1.
  - Either way, rsv_valid is cleared.
- All reads and writes occur at acceptance, so data-channel requests are strictly ordered.
- Fetch and data store to the same word in the same accept cycle: the fetch returns the pre-store value.
- Backing-store contents are not initialised by reset. A bench preloads them via hierarchical $readmemh.

## Timing
- Each channel has a LATENCY-stage valid/data pipeline.
- Stages advance when the output stage is empty or rsp_ready=1.
- req_ready = !(pipeline full && output stage held with rsp_ready=0). req_ready is combinational from rsp_ready.
- With rsp_ready held high, throughput is 1 request per cycle per channel.
- While stalled, response data and exc are stable until the handshake completes.
- On RST_N low, asynchronously: all stage valids=0, if_rsp_valid=0, d_rsp_valid=0, rsp data/exc=0, rsv_valid=0.
- Requests accepted before a mid-operation reset are dropped. Writes already performed remain.
- req_ready rises to 1 in the first cycle after RST_N deasserts.
- The two channels are fully independent; there is no cross-channel stall.

## Structure
- Package memory_pkg holds:
  - mem_op_t enum
  - mem_rsp_t struct: data, exc
  - function is_aligned(addr, XLEN)
  - function in_range(addr, BASE_ADDR, ADDR_BITS)
- Sub-module mem_rsp_pipe #(WIDTH, LATENCY) implements the backpressured valid/ready delay line. It is instantiated once per channel.
- The top level holds the byte array, exception decode, store/SC write logic and the reservation register.

## Test plan
- XLEN=32, LATENCY=1: STORE 0x8000_0010 wdata 0xDEADBEEF be 4'hF, then LOAD same address -> d_rsp_data=0xDEADBEEF, exc=0, one cycle after accept.
- Byte mask: after the above, STORE wdata 0x0000_1200 be 4'b0010, LOAD -> 0xDEAD12EF.
- LR/SC: LR 0x8000_0020 -> SC same address wdata 5 -> rsp 0, LOAD returns 5; a second SC -> rsp 1, memory unchanged.
- Reservation kill: LR 0x8000_0020, STORE 0x8000_0020, SC -> rsp 1. Separately, LOAD 0x8000_0002 -> exc=1, data 0; LOAD 0x7FFF_FFF0 -> exc=1.
- XLEN=64, LATENCY=3, d_rsp_ready low for 5 cycles with 4 LOADs issued -> at most 3 accepted, req_ready=0 once full, responses in order with stable data; no loss after ready rises.
- Reset mid-flight: 2 fetches outstanding, pulse RST_N low asynchronously -> if_rsp_valid=0 immediately; no stale response after release; rsv_valid=0 (a following SC fails).
